// File: rtl/cc_mshr_replay_queue.sv
// rtl/cc_mshr_replay_queue.sv - parks loads/stores that hit a pending MSHR entry and replays them on deallocation
//
// Purpose: requests that collide with an in-flight MSHR entry wait here until
// the MSHR update stream deallocates that entry, then are handed back to
// cache controller stage 1 over a valid/ready handshake.
//
// Ports:
//   clk, reset (sync, active-high), enable (0 freezes all state)
//   park_*        : park request from stage 2; park_ready = a slot is FREE
//   mshr_update_* : snooped MSHR update stream; update_valid=0 is a deallocation
//   replay_*      : woken request presented to stage 1 (valid/ready)
//   occupancy     : number of non-FREE slots
//   stat_park_count, stat_max_wait : only when CC_REPLAY_STATS_EN is defined
//
// Optional feature macro: CC_REPLAY_STATS_EN

module cc_mshr_replay_queue #(
  parameter int QUEUE_DEPTH  = 8,
  parameter int MSHR_ENTRIES = 8,
  parameter int TAG_W        = 20,
  parameter int SET_W        = 6,
  localparam int THREAD_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1,
  localparam int IDX_W       = (MSHR_ENTRIES > 1) ? $clog2(MSHR_ENTRIES) : 1,
  localparam int OCC_W       = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                park_valid,
  output logic                park_ready,
  input  logic [THREAD_W-1:0] park_thread,
  input  logic [TAG_W-1:0]    park_tag,
  input  logic [SET_W-1:0]    park_set,
  input  logic                park_is_store,
  input  logic [IDX_W-1:0]    park_mshr_index,
  input  logic                mshr_update_en,
  input  logic [IDX_W-1:0]    mshr_update_index,
  input  logic                mshr_update_valid,
  output logic                replay_valid,
  input  logic                replay_ready,
  output logic [THREAD_W-1:0] replay_thread,
  output logic [TAG_W-1:0]    replay_tag,
  output logic [SET_W-1:0]    replay_set,
  output logic                replay_is_store,
  output logic [OCC_W-1:0]    occupancy
`ifdef CC_REPLAY_STATS_EN
  ,
  output logic [31:0]         stat_park_count,
  output logic [15:0]         stat_max_wait
`endif
);

  typedef enum logic [1:0] {S_FREE, S_WAIT, S_READY} slot_state_e;

  slot_state_e state_q [QUEUE_DEPTH];
  slot_state_e state_d [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0][THREAD_W-1:0] thread_q, thread_d;
  logic [QUEUE_DEPTH-1:0][TAG_W-1:0]    tag_q, tag_d;
  logic [QUEUE_DEPTH-1:0][SET_W-1:0]    set_q, set_d;
  logic [QUEUE_DEPTH-1:0]               store_q, store_d;
  logic [QUEUE_DEPTH-1:0][IDX_W-1:0]    midx_q, midx_d;
  logic                                 sel_lock_q, sel_lock_d;
  logic [THREAD_W-1:0]                  sel_idx_q, sel_idx_d;
  logic [OCC_W-1:0]                     occ_q, occ_d;

  logic                free_found, ready_found, thread_busy;
  logic [THREAD_W-1:0] free_idx, ready_idx, sel_idx;
  logic                park_fire, replay_fire, dealloc;

  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    ready_found = 1'b0;
    ready_idx   = '0;
    thread_busy = 1'b0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (!free_found && state_q[i] == S_FREE) begin
        free_found = 1'b1;
        free_idx   = THREAD_W'(i);
      end
      if (!ready_found && state_q[i] == S_READY) begin
        ready_found = 1'b1;
        ready_idx   = THREAD_W'(i);
      end
      if (state_q[i] != S_FREE && thread_q[i] == park_thread) thread_busy = 1'b1;
    end

    // A presented-but-stalled request keeps its slot selected so a lower
    // slot waking later cannot change the outputs under the consumer.
    sel_idx = sel_lock_q ? sel_idx_q : ready_idx;

    park_ready      = enable & free_found;
    replay_valid    = enable & ready_found;
    replay_thread   = ready_found ? thread_q[sel_idx] : '0;
    replay_tag      = ready_found ? tag_q[sel_idx]    : '0;
    replay_set      = ready_found ? set_q[sel_idx]    : '0;
    replay_is_store = ready_found ? store_q[sel_idx]  : 1'b0;

    park_fire   = park_valid & park_ready;
    replay_fire = replay_valid & replay_ready;
    dealloc     = mshr_update_en & ~mshr_update_valid & enable;

    state_d  = state_q;
    thread_d = thread_q;
    tag_d    = tag_q;
    set_d    = set_q;
    store_d  = store_q;
    midx_d   = midx_q;

    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (dealloc && state_q[i] == S_WAIT && midx_q[i] == mshr_update_index)
        state_d[i] = S_READY;
    end
    if (replay_fire) state_d[sel_idx] = S_FREE;
    // free_idx is FREE in registered state, so it never aliases sel_idx.
    if (park_fire) begin
      state_d[free_idx]  = (dealloc && park_mshr_index == mshr_update_index) ? S_READY : S_WAIT;
      thread_d[free_idx] = park_thread;
      tag_d[free_idx]    = park_tag;
      set_d[free_idx]    = park_set;
      store_d[free_idx]  = park_is_store;
      midx_d[free_idx]   = park_mshr_index;
    end

    sel_lock_d = sel_lock_q;
    sel_idx_d  = sel_idx_q;
    if (replay_fire) begin
      sel_lock_d = 1'b0;
    end else if (replay_valid) begin
      sel_lock_d = 1'b1;
      sel_idx_d  = sel_idx;
    end

    occ_d = occ_q + OCC_W'(park_fire) - OCC_W'(replay_fire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) state_q[i] <= S_FREE;
      thread_q   <= '0;
      tag_q      <= '0;
      set_q      <= '0;
      store_q    <= '0;
      midx_q     <= '0;
      sel_lock_q <= 1'b0;
      sel_idx_q  <= '0;
      occ_q      <= '0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) state_q[i] <= state_d[i];
      thread_q   <= thread_d;
      tag_q      <= tag_d;
      set_q      <= set_d;
      store_q    <= store_d;
      midx_q     <= midx_d;
      sel_lock_q <= sel_lock_d;
      sel_idx_q  <= sel_idx_d;
      occ_q      <= occ_d;
    end
  end

  assign occupancy = occ_q;

  always_ff @(posedge clk) begin
    if (!reset && enable && park_valid) begin
      assert (free_found) else $error("park while park_ready=0");
      assert (!thread_busy) else $error("park from thread %0d already parked", park_thread);
    end
  end

`ifdef CC_REPLAY_STATS_EN
  logic [QUEUE_DEPTH-1:0][15:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]                  park_cnt_q, park_cnt_d;
  logic [15:0]                  max_wait_q, max_wait_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    park_cnt_d = park_cnt_q;
    max_wait_d = max_wait_q;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (enable && state_q[i] == S_WAIT && wait_cnt_q[i] != 16'hFFFF)
        wait_cnt_d[i] = wait_cnt_q[i] + 16'd1;
      if (wait_cnt_d[i] > max_wait_d) max_wait_d = wait_cnt_d[i];
    end
    if (park_fire) begin
      wait_cnt_d[free_idx] = '0;
      if (park_cnt_q != 32'hFFFF_FFFF) park_cnt_d = park_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      park_cnt_q <= '0;
      max_wait_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      park_cnt_q <= park_cnt_d;
      max_wait_q <= max_wait_d;
    end
  end

  assign stat_park_count = park_cnt_q;
  assign stat_max_wait   = max_wait_q;
`endif

endmodule

// File: doc/cc_mshr_replay_queue.md
Name: cc_mshr_replay_queue

Overview:
- Sits directly downstream of the cache controller MSHR lookup port.
- A core load/store that hits a pending MSHR entry (same block, transaction in flight) is parked here with the MSHR index it collided on.
- The queue snoops the MSHR update stream. When that entry is deallocated, the parked request is woken and handed back to cache controller stage 1 for replay over a valid/ready handshake.

Parameters:
- QUEUE_DEPTH, default 8 (= `THREAD_NUMB`): number of park slots; one outstanding request per HW thread.
- MSHR_ENTRIES, default `MSHR_SIZE`: number of MSHR entries; width of mshr_idx_t.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  global stage enable; 0 freezes all state.
- park_valid  in  1  stage 2 request to park (MSHR lookup_hit on a load/store).
- park_ready  out  1  a free slot exists; park accepted when park_valid & park_ready & enable.
- park_thread  in  thread_id_t  requesting thread.
- park_tag  in  dcache_tag_t  request tag.
- park_set  in  dcache_set_t  request set.
- park_is_store  in  1  1 = store, 0 = load.
- park_mshr_index  in  mshr_idx_t  MSHR entry the request collided with (lookup_index).
- mshr_update_en  in  1  copy of MSHR update_en.
- mshr_update_index  in  mshr_idx_t  copy of MSHR update_index.
- mshr_update_valid  in  1  update_entry.valid; 0 means deallocation.
- replay_valid  out  1  a woken request is presented.
- replay_ready  in  1  stage 1 accepts the replay.
- replay_thread  out  thread_id_t  thread of presented request.
- replay_tag  out  dcache_tag_t  tag of presented request.
- replay_set  out  dcache_set_t  set of presented request.
- replay_is_store  out  1  op of presented request.
- occupancy  out  $clog2(QUEUE_DEPTH)+1  number of non-FREE slots.

Behaviour:
- Per-slot state machine: FREE -> WAIT -> READY -> FREE. Fields per slot: thread, tag, set, is_store, mshr_index.
- Reset (synchronous, clk edge with reset=1):
  - All slots FREE.
  - Outputs: replay_valid=0, occupancy=0, park_ready=1, replay_* data=0.
  - Reset mid-operation discards all parked requests with no replay.
- Allocation:
  - Accepted park writes the lowest-index FREE slot.
  - park_ready is combinational and equals "any slot FREE" from registered state only. A slot freed by a replay in the same cycle is not reusable until the next cycle.
- Wake:
  - A deallocation is mshr_update_en & ~mshr_update_valid & enable.
  - Every WAIT slot with mshr_index == mshr_update_index moves to READY next cycle. Multiple slots may wake at once.
  - Updates with mshr_update_valid=1 (state changes, ack counts) do not wake.
- Bypass: a park accepted in the same cycle as a deallocation of its own park_mshr_index enters READY directly, not WAIT, so it cannot miss its wakeup.
- Replay select:
  - The lowest-index READY slot, combinational from registered state.
  - replay_valid = any READY; replay_* show the selected slot's fields.
  - On replay_valid & replay_ready & enable, that slot goes FREE next cycle.
  - While replay_valid=1 and replay_ready=0, the selected slot and its outputs stay stable. A lower-index slot becoming READY later does not pre-empt an already presented request.
  - Implement this by latching the selection while stalled.
- Latency:
  - Park at cycle t, dealloc at t+k (k≥1): replay_valid asserted at t+k+1 at the earliest.
  - Park with same-cycle dealloc: replay_valid at t+1.
- Occupancy: registered; updated +1 on park, -1 on replay, unchanged when both happen in the same cycle.
- enable=0:
  - No park, wake, or replay takes effect.
  - park_ready and replay_valid are forced to 0; slot state is held.
  - Deallocations seen while enable=0 are lost; the codebase guarantees the MSHR is also disabled then.
- Error checks (simulation assertions, $error):
  - Park from a thread that already occupies a slot.
  - Park while park_ready=0.
  - Replay accepted while replay_valid=0 is ignored and does not fire the assertion.

Optional Feature:
- Macro CC_REPLAY_STATS_EN adds output stat_park_count, 32 bits, and output stat_max_wait, 16 bits.
  - stat_park_count counts accepted parks.
  - stat_max_wait is the largest number of cycles any slot spent in WAIT; a per-slot 16-bit counter saturates at 0xFFFF.
  - Both reset to 0 and saturate rather than wrap.
- Without the macro, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
- Reset then idle -> park_ready=1, replay_valid=0, occupancy=0.
- Park thread 3 (tag 0x1A, set 5, load) on mshr_index 2; at t+4 update_en, index 2, valid=0 -> replay_valid=1 at t+5 with thread 3, tag 0x1A, set 5; replay_ready=1 -> occupancy returns to 0 next cycle.
- Park threads 0, 1 and 4 on mshr_index 6; update index 6 with valid=1 -> no wake; then valid=0 -> all three READY, replayed in slot order 0, 1, 2 over three cycles with replay_ready held 1.
- Park thread 2 on index 1 in the same cycle as a dealloc of index 1 -> replay_valid=1 next cycle; bypass check.
- Fill all 8 slots -> park_ready=0, occupancy=8; hold replay_ready=0 for 5 cycles after a wake -> replay outputs stable; assert reset mid-stall -> all slots cleared, replay_valid=0 next cycle.
- With CC_REPLAY_STATS_EN: park thread 0, dealloc after 10 cycles -> stat_park_count=1, stat_max_wait=10.
